// File: rtl/xor_link_arbiter.sv
// Round-robin arbiter sharing one XOR-keyed transmit line between two requesters.
// Frames are a plaintext header followed by FRAME_LEN payload bytes with a rolling per-byte key.
module xor_link_arbiter #(
    parameter int unsigned FRAME_LEN = 4,
    parameter logic [7:0]  KEY_STEP  = 8'h01
) (
    input  logic       clk_bar,
    input  logic       clr_bar,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [7:0] cfg_key,
    output logic [7:0] tx_data,
    output logic [7:0] tx_key,
    output logic       tx_valid,
    output logic       tx_src,
    output logic       frame_start,
    output logic       busy
);

    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             last_grant_q, last_grant_d;
    logic             tx_src_q, tx_src_d;
    logic [7:0]       frame_key_q, frame_key_d;
    logic [7:0]       base_key0_q, base_key0_d;
    logic [7:0]       base_key1_q, base_key1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       tx_key_q, tx_key_d;
    logic             tx_valid_q, tx_valid_d;
    logic             frame_start_q, frame_start_d;

    logic             grant;
    logic             sel_valid;
    logic [7:0]       sel_data;

    // State and output registers
    always_ff @(posedge clk_bar or posedge clr_bar) begin
        if (clr_bar) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            last_grant_q  <= 1'b1;
            tx_src_q      <= 1'b0;
            frame_key_q   <= 8'h00;
            base_key0_q   <= 8'h00;
            base_key1_q   <= 8'h00;
            idx_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_key_q      <= 8'h00;
            tx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            last_grant_q  <= last_grant_d;
            tx_src_q      <= tx_src_d;
            frame_key_q   <= frame_key_d;
            base_key0_q   <= base_key0_d;
            base_key1_q   <= base_key1_d;
            idx_q         <= idx_d;
            tx_data_q     <= tx_data_d;
            tx_key_q      <= tx_key_d;
            tx_valid_q    <= tx_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next-state, arbitration and datapath
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        tx_src_d      = tx_src_q;
        frame_key_d   = frame_key_q;
        base_key0_d   = base_key0_q;
        base_key1_d   = base_key1_q;
        idx_d         = idx_q;
        tx_data_d     = tx_data_q;
        tx_key_d      = tx_key_q;
        tx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        grant         = 1'b0;
        sel_valid     = tx_src_q ? req1_valid : req0_valid;
        sel_data      = tx_src_q ? req1_data : req0_data;

        if (cfg_we) begin
            if (cfg_sel) base_key1_d = cfg_key;
            else         base_key0_d = cfg_key;
        end

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant         = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    state_d       = HEADER;
                    tx_src_d      = grant;
                    last_grant_d  = grant;
                    // Old base key is latched even if cfg_we hits the same edge
                    frame_key_d   = grant ? base_key1_q : base_key0_q;
                    tx_valid_d    = 1'b1;
                    tx_data_d     = {4'hA, 3'b000, grant};
                    tx_key_d      = 8'h00;
                    frame_start_d = 1'b1;
                end
            end
            HEADER: begin
                state_d = PAYLOAD;
                idx_d   = '0;
            end
            PAYLOAD: begin
                req0_ready = ~tx_src_q;
                req1_ready = tx_src_q;
                if (sel_valid) begin
                    tx_data_d  = sel_data;
                    tx_key_d   = frame_key_q + 8'(idx_q) * KEY_STEP;
                    tx_valid_d = 1'b1;
                    idx_d      = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_data     = tx_data_q;
    assign tx_key      = tx_key_q;
    assign tx_valid    = tx_valid_q;
    assign tx_src      = tx_src_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_xor_link_arbiter.sv
// Directed bench for xor_link_arbiter: vector table for the main frame flow plus
// hand-written reset and round-robin sequences.
module tb_xor_link_arbiter;

    logic       clk_bar = 1'b0;
    logic       clr_bar;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       cfg_we, cfg_sel;
    logic [7:0] cfg_key;
    logic [7:0] tx_data, tx_key;
    logic       tx_valid, tx_src, frame_start, busy;

    int errors = 0;
    int checks = 0;

    xor_link_arbiter #(.FRAME_LEN(4), .KEY_STEP(8'h01)) dut (
        .clk_bar(clk_bar), .clr_bar(clr_bar),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_key(cfg_key),
        .tx_data(tx_data), .tx_key(tx_key), .tx_valid(tx_valid),
        .tx_src(tx_src), .frame_start(frame_start), .busy(busy)
    );

    always #5 clk_bar = ~clk_bar;

    typedef struct {
        logic       r0v;
        logic [7:0] d0;
        logic       r1v;
        logic [7:0] d1;
        logic       we;
        logic       sel;
        logic [7:0] key;
        logic       tv;
        logic [7:0] td;
        logic [7:0] tk;
        logic       src;
        logic       fs;
        logic       bsy;
        logic       rdy0;
        logic       rdy1;
    } vec_t;

    localparam int unsigned NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r0v, logic [7:0] d0, logic r1v, logic [7:0] d1,
                                logic we, logic sel, logic [7:0] key,
                                logic tv, logic [7:0] td, logic [7:0] tk, logic src,
                                logic fs, logic bsy, logic rdy0, logic rdy1);
        vec_t v;
        v.r0v = r0v; v.d0 = d0; v.r1v = r1v; v.d1 = d1;
        v.we = we; v.sel = sel; v.key = key;
        v.tv = tv; v.td = td; v.tk = tk; v.src = src;
        v.fs = fs; v.bsy = bsy; v.rdy0 = rdy0; v.rdy1 = rdy1;
        return v;
    endfunction

    task automatic check(input string name, input int step_no, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_bar);
        #1;
    endtask

    task automatic wait_fs(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input int step_no);
        check("rst_tx_valid", step_no, 8'(tx_valid), 8'h00);
        check("rst_tx_data", step_no, tx_data, 8'h00);
        check("rst_tx_key", step_no, tx_key, 8'h00);
        check("rst_tx_src", step_no, 8'(tx_src), 8'h00);
        check("rst_frame_start", step_no, 8'(frame_start), 8'h00);
        check("rst_busy", step_no, 8'(busy), 8'h00);
        check("rst_ready0", step_no, 8'(req0_ready), 8'h00);
        check("rst_ready1", step_no, 8'(req1_ready), 8'h00);
    endtask

    initial begin
        bit ok;

        // r0v d0 r1v d1 we sel key | tv td tk src fs busy rdy0 rdy1
        vecs[0]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h10, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 8'h00, 1, 8'hA0, 8'h00, 0, 1, 1, 0, 0);
        vecs[2]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        vecs[3]  = mk(1, 8'h11, 0, 8'h00, 0, 0, 8'h00, 1, 8'h11, 8'h10, 0, 0, 1, 1, 0);
        vecs[4]  = mk(1, 8'h22, 0, 8'h00, 0, 0, 8'h00, 1, 8'h22, 8'h11, 0, 0, 1, 1, 0);
        vecs[5]  = mk(1, 8'h33, 0, 8'h00, 0, 0, 8'h00, 1, 8'h33, 8'h12, 0, 0, 1, 1, 0);
        vecs[6]  = mk(1, 8'h44, 0, 8'h00, 0, 0, 8'h00, 1, 8'h44, 8'h13, 0, 0, 1, 0, 0);
        vecs[7]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'hFE, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 8'h00, 1, 8'hC1, 0, 0, 8'h00, 1, 8'hA1, 8'h00, 1, 1, 1, 0, 0);
        vecs[9]  = mk(1, 8'hEE, 1, 8'hC1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 1, 0, 1);
        vecs[10] = mk(1, 8'hEE, 1, 8'hC1, 0, 0, 8'h00, 1, 8'hC1, 8'hFE, 1, 0, 1, 0, 1);
        vecs[11] = mk(1, 8'hEE, 1, 8'hC2, 0, 0, 8'h00, 1, 8'hC2, 8'hFF, 1, 0, 1, 0, 1);
        vecs[12] = mk(1, 8'hEE, 1, 8'hC3, 0, 0, 8'h00, 1, 8'hC3, 8'h00, 1, 0, 1, 0, 1);
        vecs[13] = mk(1, 8'hEE, 1, 8'hC4, 0, 0, 8'h00, 1, 8'hC4, 8'h01, 1, 0, 1, 0, 0);
        vecs[14] = mk(1, 8'hEE, 1, 8'hC5, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 8'h51, 1, 8'hC5, 0, 0, 8'h00, 1, 8'hA0, 8'h00, 0, 1, 1, 0, 0);
        vecs[16] = mk(1, 8'h51, 1, 8'hC5, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        vecs[17] = mk(1, 8'h51, 1, 8'hC5, 0, 0, 8'h00, 1, 8'h51, 8'h10, 0, 0, 1, 1, 0);
        vecs[18] = mk(1, 8'h52, 1, 8'hC5, 0, 0, 8'h00, 1, 8'h52, 8'h11, 0, 0, 1, 1, 0);
        vecs[19] = mk(0, 8'h53, 1, 8'hC5, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        vecs[20] = mk(0, 8'h53, 1, 8'hC5, 1, 0, 8'h55, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        vecs[21] = mk(0, 8'h53, 1, 8'hC5, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        vecs[22] = mk(1, 8'h53, 0, 8'h00, 0, 0, 8'h00, 1, 8'h53, 8'h12, 0, 0, 1, 1, 0);
        vecs[23] = mk(1, 8'h54, 0, 8'h00, 0, 0, 8'h00, 1, 8'h54, 8'h13, 0, 0, 1, 0, 0);
        vecs[24] = mk(1, 8'h61, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        vecs[25] = mk(1, 8'h61, 0, 8'h00, 1, 0, 8'h77, 1, 8'hA0, 8'h00, 0, 1, 1, 0, 0);
        vecs[26] = mk(1, 8'h61, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
        vecs[27] = mk(1, 8'h61, 0, 8'h00, 0, 0, 8'h00, 1, 8'h61, 8'h55, 0, 0, 1, 1, 0);
        vecs[28] = mk(1, 8'h62, 0, 8'h00, 0, 0, 8'h00, 1, 8'h62, 8'h56, 0, 0, 1, 1, 0);

        clr_bar = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_data = 8'h00;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_key = 8'h00;
        #2;
        check_all_zero(-1);
        step();
        clr_bar = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            req0_valid = vecs[i].r0v; req0_data = vecs[i].d0;
            req1_valid = vecs[i].r1v; req1_data = vecs[i].d1;
            cfg_we = vecs[i].we; cfg_sel = vecs[i].sel; cfg_key = vecs[i].key;
            step();
            check("tx_valid", i, 8'(tx_valid), 8'(vecs[i].tv));
            check("frame_start", i, 8'(frame_start), 8'(vecs[i].fs));
            check("busy", i, 8'(busy), 8'(vecs[i].bsy));
            check("req0_ready", i, 8'(req0_ready), 8'(vecs[i].rdy0));
            check("req1_ready", i, 8'(req1_ready), 8'(vecs[i].rdy1));
            if (vecs[i].tv) begin
                check("tx_data", i, tx_data, vecs[i].td);
                check("tx_key", i, tx_key, vecs[i].tk);
            end
            if (vecs[i].bsy) check("tx_src", i, 8'(tx_src), 8'(vecs[i].src));
        end
        cfg_we = 1'b0;

        // Mid-payload reset: outputs clear without waiting for a clock edge
        clr_bar = 1'b1;
        req0_valid = 1'b0;
        #1;
        check_all_zero(100);
        step();
        clr_bar = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h99;
        step();
        check("post_rst_fs", 101, 8'(frame_start), 8'h01);
        check("post_rst_hdr", 101, tx_data, 8'hA1);
        check("post_rst_src", 101, 8'(tx_src), 8'h01);
        step();
        step();
        check("post_rst_key0", 103, tx_key, 8'h00);
        check("post_rst_data0", 103, tx_data, 8'h99);

        // Both requesters from reset: req0 first, then strict alternation
        clr_bar = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h0A;
        req1_valid = 1'b1; req1_data = 8'h0B;
        step();
        clr_bar = 1'b0;
        step();
        check("rr_first_fs", 200, 8'(frame_start), 8'h01);
        check("rr_first_src", 200, 8'(tx_src), 8'h00);
        check("rr_first_hdr", 200, tx_data, 8'hA0);
        for (int f = 1; f <= 2; f++) begin
            wait_fs(20, ok);
            check("rr_fs_seen", 200 + f, 8'(ok), 8'h01);
            check("rr_src", 200 + f, 8'(tx_src), 8'(f % 2));
            check("rr_hdr", 200 + f, tx_data, 8'hA0 | 8'(f % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
